// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and helpers for the mux select arbiter.
package mux_sel_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_HOLD_DEF = 8;

  // Hold counter width; at least one bit so MAX_HOLD=1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return (max_hold <= 2) ? 1 : $clog2(max_hold);
  endfunction

  localparam int unsigned CNT_W = cnt_width(MAX_HOLD_DEF);

  // Index of the set bit of a one-hot grant (up to 4 requesters).
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from ptr, or fixed lowest-index priority.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] win_idx,
  output logic             win_any
);

  // First pass honours the pointer (round-robin only); second pass wraps to index 0.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!win_any && req[i] && (pass == 1 || !mode || i >= 32'(ptr))) begin
          win_any = 1'b1;
          win_idx = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Arbiter driving the 3:1 output mux select: registered select, one-hot grant,
// multi-beat hold with forced release at MAX_HOLD beats.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             req_last,
  input  logic             beat,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic [N_REQ-1:0] grant,
  output logic             hold_timeout
);

  localparam int unsigned     CW      = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_HOLD - 1);
  localparam logic            RR      = (RR_MODE != 0);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
  logic              r_valid, w_valid_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_to, w_to_nxt;

  logic [N_REQ-1:0]  w_arb_req;
  logic [SEL_W-1:0]  w_pick_ptr;
  logic [SEL_W-1:0]  w_win_idx;
  logic              w_win_any;
  logic              w_held;
  logic              w_at_max;
  logic              w_release;
  logic              w_take;

  assign w_held     = |(req & r_grant);
  assign w_at_max   = (r_cnt == CNT_MAX);
  assign w_release  = !w_held || (beat && (req_last || w_at_max));
  // In round-robin mode the requester being released is excluded from the re-arbitration.
  assign w_arb_req  = (RR && r_state == GRANT) ? (req & ~r_grant) : req;
  assign w_pick_ptr = RR ? r_ptr : '0;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (w_arb_req),
    .ptr     (w_pick_ptr),
    .mode    (RR),
    .win_idx (w_win_idx),
    .win_any (w_win_any)
  );

  // Next-state, next-output and hold-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_valid_nxt = r_valid;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        w_take = w_win_any;
      end
      GRANT: begin
        if (w_release) begin
          w_to_nxt = beat && w_at_max && !req_last;
          if (w_win_any) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_grant_nxt = '0;
          end
        end else if (beat && !w_at_max) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_take) begin
      w_state_nxt = GRANT;
      w_sel_nxt   = w_win_idx;
      w_grant_nxt = N_REQ'(1) << w_win_idx;
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = '0;
      if (RR) begin
        w_ptr_nxt = (w_win_idx == SEL_W'(N_REQ - 1)) ? '0 : w_win_idx + SEL_W'(1);
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign sel          = r_sel;
  assign sel_valid    = r_valid;
  assign grant        = r_grant;
  assign hold_timeout = r_to;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench: round-robin instance driven from a vector table plus
// hold-limit sequences; fixed-priority instance driven by a short hand sequence.
module tb_mux_sel_arbiter;
  import mux_sel_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned MH = MAX_HOLD_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rr_rst, rr_last, rr_beat;
  logic [N-1:0]  rr_req;
  logic [SW-1:0] rr_sel;
  logic          rr_valid, rr_to;
  logic [N-1:0]  rr_grant;

  logic          fp_rst, fp_last, fp_beat;
  logic [N-1:0]  fp_req;
  logic [SW-1:0] fp_sel;
  logic          fp_valid, fp_to;
  logic [N-1:0]  fp_grant;

  mux_sel_arbiter #(.N_REQ(N), .SEL_W(SW), .RR_MODE(1), .MAX_HOLD(MH)) u_rr (
    .clk(clk), .rst(rr_rst), .req(rr_req), .req_last(rr_last), .beat(rr_beat),
    .sel(rr_sel), .sel_valid(rr_valid), .grant(rr_grant), .hold_timeout(rr_to)
  );

  mux_sel_arbiter #(.N_REQ(N), .SEL_W(SW), .RR_MODE(0), .MAX_HOLD(MH)) u_fp (
    .clk(clk), .rst(fp_rst), .req(fp_req), .req_last(fp_last), .beat(fp_beat),
    .sel(fp_sel), .sel_valid(fp_valid), .grant(fp_grant), .hold_timeout(fp_to)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        inv_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag, input logic [SW-1:0] s, input logic v,
                          input logic [N-1:0] g, input logic t);
    check({tag, ".sel"},   32'(rr_sel),   32'(s));
    check({tag, ".valid"}, 32'(rr_valid), 32'(v));
    check({tag, ".grant"}, 32'(rr_grant), 32'(g));
    check({tag, ".to"},    32'(rr_to),    32'(t));
  endtask

  task automatic check_fp(input string tag, input logic [SW-1:0] s, input logic v,
                          input logic [N-1:0] g, input logic t);
    check({tag, ".sel"},   32'(fp_sel),   32'(s));
    check({tag, ".valid"}, 32'(fp_valid), 32'(v));
    check({tag, ".grant"}, 32'(fp_grant), 32'(g));
    check({tag, ".to"},    32'(fp_to),    32'(t));
  endtask

  // Structural invariants on both instances, sampled on the falling edge.
  always @(negedge clk) begin
    if (inv_en) begin
      check("rr_onehot0", 32'($onehot0(rr_grant)), 32'd1);
      check("rr_valid_eq_grant", 32'(rr_valid), 32'(|rr_grant));
      check("fp_onehot0", 32'($onehot0(fp_grant)), 32'd1);
      check("fp_valid_eq_grant", 32'(fp_valid), 32'(|fp_grant));
      if (rr_valid) begin
        check("rr_sel_range", 32'(rr_sel < SW'(N)), 32'd1);
        check("rr_sel_idx", 32'(rr_sel), 32'(onehot_to_idx(4'(rr_grant))));
      end
      if (fp_valid) begin
        check("fp_sel_range", 32'(fp_sel < SW'(N)), 32'd1);
        check("fp_sel_idx", 32'(fp_sel), 32'(onehot_to_idx(4'(fp_grant))));
      end
    end
  end

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          last;
    logic          beat;
    logic [SW-1:0] sel;
    logic          valid;
    logic [N-1:0]  grant;
    logic          to;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [CNT_W-1:0] beat_no;

    //            rst   req     last  beat  sel    valid grant   to
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b0}; // first grant, ptr 0
    tbl[2]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd1, 1'b1, 3'b010, 1'b0}; // back-to-back RR
    tbl[3]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100, 1'b0};
    tbl[4]  = '{1'b0, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0}; // wraps to 0
    tbl[5]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b0}; // held, no beat
    tbl[6]  = '{1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0}; // beat, not last
    tbl[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0}; // withdrawal
    tbl[8]  = '{1'b0, 3'b100, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 1'b0}; // ptr 1 -> picks 2
    tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 1'b0}; // withdraw, sel holds 2
    tbl[10] = '{1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000, 1'b0}; // beat while idle
    tbl[11] = '{1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b0}; // ptr -> 1
    tbl[12] = '{1'b1, 3'b011, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0}; // reset mid-grant
    tbl[13] = '{1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b0}; // ptr back to 0
    tbl[14] = '{1'b1, 3'b100, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0}; // reset during grant
    tbl[15] = '{1'b0, 3'b100, 1'b0, 1'b0, 2'd2, 1'b1, 3'b100, 1'b0}; // sel=2 one cycle later

    rr_rst = 1'b1; rr_req = '0; rr_last = 1'b0; rr_beat = 1'b0;
    fp_rst = 1'b1; fp_req = '0; fp_last = 1'b0; fp_beat = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rr_rst  = tbl[i].rst;
      rr_req  = tbl[i].req;
      rr_last = tbl[i].last;
      rr_beat = tbl[i].beat;
      tick();
      inv_en = 1'b1;
      check_rr($sformatf("vec%0d", i), tbl[i].sel, tbl[i].valid, tbl[i].grant, tbl[i].to);
    end

    // Forced release after MAX_HOLD beats without req_last.
    rr_req = 3'b000; rr_last = 1'b0; rr_beat = 1'b0;
    tick();
    check_rr("to_idle", 2'd2, 1'b0, 3'b000, 1'b0);
    rr_req = 3'b001;
    tick();
    check_rr("to_grant", 2'd0, 1'b1, 3'b001, 1'b0);
    rr_beat = 1'b1;
    beat_no = '0;
    for (int b = 1; b < int'(MH); b++) begin
      tick();
      beat_no = beat_no + 1'b1;
      check_rr($sformatf("to_beat%0d", beat_no), 2'd0, 1'b1, 3'b001, 1'b0);
    end
    tick();
    check_rr("to_release", 2'd0, 1'b0, 3'b000, 1'b1);
    rr_beat = 1'b0;
    tick();
    check_rr("to_pulse_end", 2'd0, 1'b1, 3'b001, 1'b0);

    // req_last coinciding with the count limit: normal release, no pulse.
    rr_beat = 1'b1;
    for (int b = 1; b < int'(MH); b++) begin
      tick();
      check_rr($sformatf("last_beat%0d", b), 2'd0, 1'b1, 3'b001, 1'b0);
    end
    rr_last = 1'b1;
    tick();
    check_rr("last_release", 2'd0, 1'b0, 3'b000, 1'b0);

    // Forced release with another requester pending: no bubble, pulse still fires.
    rr_last = 1'b0; rr_beat = 1'b0; rr_req = 3'b011;
    tick();
    check_rr("to_b2b_grant", 2'd1, 1'b1, 3'b010, 1'b0);
    rr_beat = 1'b1;
    for (int b = 1; b < int'(MH); b++) tick();
    check_rr("to_b2b_hold", 2'd1, 1'b1, 3'b010, 1'b0);
    tick();
    check_rr("to_b2b_next", 2'd0, 1'b1, 3'b001, 1'b1);
    rr_beat = 1'b0;
    tick();
    check_rr("to_b2b_after", 2'd0, 1'b1, 3'b001, 1'b0);

    // Fixed priority: requester 2 starved while 1 keeps requesting.
    tick();
    check_fp("fp_reset", 2'd0, 1'b0, 3'b000, 1'b0);
    fp_rst = 1'b0; fp_req = 3'b110;
    tick();
    check_fp("fp_grant1", 2'd1, 1'b1, 3'b010, 1'b0);
    fp_beat = 1'b1; fp_last = 1'b1;
    tick();
    check_fp("fp_regrant1a", 2'd1, 1'b1, 3'b010, 1'b0);
    tick();
    check_fp("fp_regrant1b", 2'd1, 1'b1, 3'b010, 1'b0);
    fp_req = 3'b111;
    tick();
    check_fp("fp_grant0", 2'd0, 1'b1, 3'b001, 1'b0);
    fp_beat = 1'b0; fp_last = 1'b0; fp_req = 3'b100;
    tick();
    check_fp("fp_withdraw_to2", 2'd2, 1'b1, 3'b100, 1'b0);

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
